data_mem_hs: RTL and testbench

//  Parametrised data memory for the multi-cycle datapath. It replaces the fixed 1K-word, combinational-read memory.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_sram.sv | 35 +++
 rtl/data_mem_hs.sv | 143 ++++++++++++++
 tb/tb_data_mem_hs.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the handshaked data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Misaligned low bits fall away here: a half only looks at off[1], a word ignores off.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 data array split into four byte-lane arrays, each with its own write enable
// and a registered read port so every lane maps onto block RAM.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_hs.sv
// Data memory with valid/ready handshake, programmable latency and sized, extended accesses.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of clearing low address bits.
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              we_reg, uns_reg, err_reg;
    logic [1:0]        size_reg, off_reg;
    logic [AW-1:0]     idx_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              accept, access, decode_err;
    logic              sram_wr, sram_rd;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata_lanes, sram_rdata;

    assign accept = req_valid && (state_reg == IDLE);
    assign access = (state_reg == WAIT) && (cnt_reg == CW'(1));

    // Faults are decided at accept time and carried with the request, so a faulting
    // access still walks through the full latency before it answers.
    always_comb begin
        decode_err = ((req_addr >> (AW + 2)) != 32'h0) || (req_size == SZ_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (req_size == SZ_HALF && req_addr[0]) begin
            decode_err = 1'b1;
        end
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) begin
            decode_err = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CW'(LATENCY);
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= SZ_BYTE;
            off_reg   <= 2'b00;
            idx_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                err_reg   <= decode_err;
                size_reg  <= req_size;
                off_reg   <= req_addr[1:0];
                idx_reg   <= req_addr[AW+1:2];
                wdata_reg <= req_wdata;
            end
        end
    end

    // Right-aligned store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        case (size_reg)
            SZ_BYTE: wdata_lanes = {4{wdata_reg[7:0]}};
            SZ_HALF: wdata_lanes = {2{wdata_reg[15:0]}};
            default: wdata_lanes = wdata_reg;
        endcase
    end

    assign be      = byte_enables(size_reg, off_reg);
    assign sram_wr = access && we_reg && !err_reg;
    assign sram_rd = access && !we_reg && !err_reg;

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .wr_en (sram_wr),
        .rd_en (sram_rd),
        .be    (be),
        .addr  (idx_reg),
        .wdata (wdata_lanes),
        .rdata (sram_rdata)
    );

    // The read register only reloads on an access edge, so data stays put while RESP stalls.
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_rdata = (rsp_valid && !err_reg && !we_reg)
                     ? load_extend(sram_rdata, size_reg, off_reg, uns_reg) : '0;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs at LATENCY=3, DEPTH=1024.
module tb_data_mem_hs;
    import dmem_pkg::*;

    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    exp_t got, want;
    int   lat;
    bit   stable, blocked, send_to;
    logic ready_after, valid_after;

    always #5 clk = ~clk;

    data_mem_hs #(
        .DATA_W  (32),
        .DEPTH   (1024),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    // Drive a request and return right after the accepting edge; expected result queued on accept.
    task automatic send(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err, input bit push);
        int waited = 0;
        send_to = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            send_to = 1'b1;
            req_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back('{exp_rd, exp_err});
        @(posedge clk);
    endtask

    // Wait for the response, optionally stall it for `hold` cycles, then complete the handshake.
    task automatic collect(input int hold, input bit pend);
        bit to = 1'b0;
        lat = 0; stable = 1'b1; blocked = 1'b1;
        forever begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid === 1'b1) break;
            if (lat >= 50) begin to = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        if (to) begin
            lat = -1; got = '0; ready_after = 1'b0; valid_after = 1'b1;
            return;
        end
        got = '{rsp_rdata, rsp_err};
        if (req_ready !== 1'b0) blocked = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid = pend;
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== got.rdata || rsp_err !== got.err) stable = 1'b0;
            if (req_ready !== 1'b0) blocked = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        ready_after = req_ready;
        valid_after = rsp_valid;
    endtask

    task automatic xact(input vec_t v, input int hold, input bit pend);
        send(v.we, v.size, v.uns, v.addr, v.wdata, v.rd, v.err, 1'b1);
        if (send_to) begin
            lat = -1; got = '0; want = '{v.rd, v.err};
        end else begin
            collect(hold, pend);
            want = sb_q.pop_front();
        end
        $display("txn we=%b size=%b uns=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
                 v.we, v.size, v.uns, v.addr, v.wdata, got.rdata, got.err, lat);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        vec_t v[2] = '{
            '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0}
        };
        for (int i = 0; i < 2; i++) begin
            xact(v[i], 0, 1'b0);
            vectors++;
            if (got !== want || lat != LAT) begin
                miscompares++;
                $display("FAIL word[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, got.rdata, got.err, lat, want.rdata, want.err, LAT);
            end
        end
    endtask

    task automatic test_byte_ext();
        vec_t v[7] = '{
            '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0},
            '{1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0},
            '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0},
            '{1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'hFFFF8022, 1'b0},
            '{1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'h00008022, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            xact(v[i], 0, 1'b0);
            vectors++;
            if (got !== want || lat != LAT) begin
                miscompares++;
                $display("FAIL byte_ext[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, got.rdata, got.err, lat, want.rdata, want.err, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t a = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0};
        vec_t b = '{1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 32'h00000044, 1'b0};
        xact(a, 5, 1'b1);
        vectors++;
        if (got !== want || lat != LAT) begin
            miscompares++;
            $display("FAIL bp_data: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     got.rdata, got.err, lat, want.rdata, want.err, LAT);
        end
        vectors++;
        if (!stable || !blocked) begin
            miscompares++;
            $display("FAIL bp_hold: got stable=%b ready_low=%b, want 1 1", stable, blocked);
        end
        vectors++;
        if (ready_after !== 1'b1 || valid_after !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got ready=%b valid=%b, want 1 0", ready_after, valid_after);
        end
        xact(b, 0, 1'b0);
        vectors++;
        if (got !== want || lat != LAT) begin
            miscompares++;
            $display("FAIL bp_next: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     got.rdata, got.err, lat, want.rdata, want.err, LAT);
        end
    endtask

    task automatic test_errors();
        vec_t v[7] = '{
            '{1'b1, SZ_WORD, 1'b0, 32'h0,    32'h5A5A5A5A, 32'h0,        1'b0},
            '{1'b1, SZ_WORD, 1'b0, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0},
            '{1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1},
            '{1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h11111111, 32'h0,        1'b1},
            '{1'b0, SZ_WORD, 1'b0, 32'h0,    32'h0,        32'h5A5A5A5A, 1'b0},
            '{1'b1, SZ_RSVD, 1'b0, 32'h20,   32'h12345678, 32'h0,        1'b1},
            '{1'b0, SZ_WORD, 1'b0, 32'h20,   32'h0,        32'hCAFEF00D, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            xact(v[i], 0, 1'b0);
            vectors++;
            if (got !== want || lat != LAT) begin
                miscompares++;
                $display("FAIL errors[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, got.rdata, got.err, lat, want.rdata, want.err, LAT);
            end
        end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        vec_t v[4] = '{
            '{1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000BEEF, 32'h0,        1'b1},
            '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0},
            '{1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0,        32'h0,        1'b1},
            '{1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1}
        };
`else
        vec_t v[4] = '{
            '{1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000BEEF, 32'h0,        1'b0},
            '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'hCAFEBEEF, 1'b0},
            '{1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0,        32'hFFFFCAFE, 1'b0},
            '{1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0,        32'hCAFEBEEF, 1'b0}
        };
`endif
        for (int i = 0; i < 4; i++) begin
            xact(v[i], 0, 1'b0);
            vectors++;
            if (got !== want || lat != LAT) begin
                miscompares++;
                $display("FAIL misalign[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, got.rdata, got.err, lat, want.rdata, want.err, LAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t clr = '{1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0};
        vec_t ld  = '{1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0};
        xact(clr, 0, 1'b0);
        vectors++;
        if (got !== want || lat != LAT) begin
            miscompares++;
            $display("FAIL mid_clear: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     got.rdata, got.err, lat, want.rdata, want.err, LAT);
        end
        send(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h12345678, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (send_to || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async: got to=%b ready=%b valid=%b rdata=%h err=%b, want 0 1 0 00000000 0",
                     send_to, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact(ld, 0, 1'b0);
        vectors++;
        if (got !== want || lat != LAT) begin
            miscompares++;
            $display("FAIL mid_discard: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     got.rdata, got.err, lat, want.rdata, want.err, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_ext();
        test_back_to_back();
        test_errors();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
